regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (r3_*) between NREQ writeback
//  requesters: ALU, load unit and mul/div. Round-robin arbitration; the winning
//  write is registered onto the write port.
//  Holds a 32-entry pending-write scoreboard. Issue logic uses it to stall reads
//  of registers that still have a write outstanding.
//  Suppresses writes to $zero, which the register file itself does not protect.
// PARAMETERS
//  NREQ  3  number of writeback requesters (2..8); index 0 = ALU
//  AW    5  register address width
//  DW    32 register data width
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         reset, asynchronous, active-low
//  req_valid     in   NREQ      requester i has a write pending
//  req_ready     out  NREQ      requester i accepted this cycle (combinational)
//  req_addr      in   NREQ*AW   dest reg, requester i at [i*AW +: AW]
//  req_data      in   NREQ*DW   write data, requester i at [i*DW +: DW]
//  alloc_valid   in   1         issue stage reserves a dest reg
//  alloc_addr    in   AW        reg being reserved
//  flush         in   1         clear all scoreboard reservations
//  rs_addr       in   AW        read address 1 being issued
//  rt_addr       in   AW        read address 2 being issued
//  rs_busy       out  1         rs_addr has an outstanding write (stall)
//  rt_busy       out  1         rt_addr has an outstanding write (stall)
//  r3_wr         out  1         register file write enable
//  r3_addr       out  AW        register file write address
//  r3_din        out  DW        register file write data
//  pending_mask  out  32        scoreboard state, bit n = reg n reserved
// BEHAVIOUR
//  Reset: r3_wr=0, r3_addr=0, r3_din=0, pending_mask=0, rr_ptr=0. req_ready
//   follows the arbitration logic; with no valid inputs it is all 0.
//  Arbitration:
//   - Search starts at rr_ptr and wraps modulo NREQ; the first i with
//     req_valid[i]=1 wins.
//   - req_ready is one-hot or zero. At most one write is accepted per cycle.
//   - Transfer = req_valid[i] & req_ready[i]. On transfer, rr_ptr <= (i+1) mod NREQ.
//   - With no transfer, rr_ptr holds.
//   - A requester keeps valid, addr and data stable until ready. The arbiter
//     never drops a valid request.
//  Write port:
//   - The edge after a transfer loads r3_addr/r3_din from the winner.
//   - r3_wr <= (winner addr != 0).
//   - With no transfer, r3_wr <= 0 and r3_addr/r3_din hold.
//   - Latency: accept at edge N, r3_wr high in cycle N+1, register file
//     updated at edge N+1.
//   - Sustained throughput is one write per cycle. No backpressure from the
//     register file.
//   - A write to $zero is accepted (ready=1) but never drives r3_wr.
//  Scoreboard, updated each edge:
//   - set(alloc_addr) when alloc_valid & alloc_addr!=0 & !flush.
//   - clr(r3_addr) when r3_wr=1.
//   - Same reg set and cleared in one cycle: set wins (new reservation).
//   - flush: pending_mask <= 0. Alloc in the same cycle is ignored. An
//     in-flight r3_wr still completes its write.
//   - pending bit 0 is constant 0.
//  Hazard outputs (combinational):
//   - rs_busy = pending_mask[rs_addr] & !(r3_wr & r3_addr==rs_addr).
//   - rt_busy is the same with rt_addr.
//   - The write-cycle exclusion is valid because the register file forwards
//     r3_din to a same-cycle read.
//   - rs_addr==0 or rt_addr==0 gives busy=0.
//  Reset mid-operation: all outputs and state return to reset values at once.
//   An accepted but unwritten transfer is lost.
// TESTING
//  1 Single write: req0 addr=5 data=0xDEADBEEF, alloc 5 beforehand. Required:
//    ready0=1 that cycle; next cycle r3_wr=1, r3_addr=5, r3_din=0xDEADBEEF.
//    pending_mask[5] goes 1 -> 0; rs_addr=5 gives rs_busy=1 until the r3_wr cycle.
//  2 Round robin: all 3 valid continuously. Required: grants in order 0,1,2,0,1,2,
//    one r3_wr per cycle. Then only req2 valid: granted every cycle.
//  3 $zero: req1 addr=0 data=0x1234. Required: ready1=1, r3_wr stays 0,
//    pending_mask stays 0. alloc addr=0 leaves pending_mask unchanged.
//  4 Collision: reg 7 pending, r3_wr to 7 and alloc 7 in the same cycle.
//    Required: pending_mask[7]=1 after the edge. Same test with flush=1:
//    pending_mask=0.
//  5 Async reset: assert rst_n=0 mid-stream while r3_wr=1. Required: r3_wr=0
//    without a clock edge, pending_mask=0. After release, the first grant goes
//    to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between requesters, issue logic and the register-file write port.
// The arbiter uses the slave modport and the requesters/issue side use master.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               alloc_valid;
  logic [AW-1:0]      alloc_addr;
  logic               flush;
  logic [AW-1:0]      rs_addr;
  logic [AW-1:0]      rt_addr;
  logic               rs_busy;
  logic               rt_busy;
  logic               r3_wr;
  logic [AW-1:0]      r3_addr;
  logic [DW-1:0]      r3_din;
  logic [31:0]        pending_mask;

  modport master (
    output req_valid, req_addr, req_data, alloc_valid, alloc_addr, flush, rs_addr, rt_addr,
    input  req_ready, rs_busy, rt_busy, r3_wr, r3_addr, r3_din, pending_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data, alloc_valid, alloc_addr, flush, rs_addr, rt_addr,
    output req_ready, rs_busy, rt_busy, r3_wr, r3_addr, r3_din, pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// pending-write scoreboard that drives read-hazard stalls for issue.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREGS = 32;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win;
  logic [PW:0]      idx;
  logic             found;
  logic [AW-1:0]    addr_a [NREQ];
  logic [DW-1:0]    data_a [NREQ];
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic             r3_wr_q;
  logic [AW-1:0]    r3_addr_q;
  logic [DW-1:0]    r3_din_q;
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_nxt;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = bus.req_addr[g*AW +: AW];
    assign data_a[g] = bus.req_data[g*DW +: DW];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (PW+1)'(rr_ptr) + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && bus.req_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_addr      = addr_a[win];
  assign win_data      = data_a[win];
  assign bus.req_ready = found ? (NREQ'(1) << win) : '0;

  // Set beats clear on the same register; flush beats both
  always_comb begin
    pending_nxt = pending_q;
    if (r3_wr_q) pending_nxt[r3_addr_q] = 1'b0;
    if (bus.flush) begin
      pending_nxt = '0;
    end else if (bus.alloc_valid && (bus.alloc_addr != '0)) begin
      pending_nxt[bus.alloc_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      r3_wr_q   <= 1'b0;
      r3_addr_q <= '0;
      r3_din_q  <= '0;
      pending_q <= '0;
    end else begin
      if (found) begin
        rr_ptr    <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
        r3_wr_q   <= (win_addr != '0);
        r3_addr_q <= win_addr;
        r3_din_q  <= win_data;
      end else begin
        r3_wr_q   <= 1'b0;
      end
      pending_q <= pending_nxt;
    end
  end

  assign bus.r3_wr        = r3_wr_q;
  assign bus.r3_addr      = r3_addr_q;
  assign bus.r3_din       = r3_din_q;
  assign bus.pending_mask = pending_q;

  // The register file forwards r3_din to a same-cycle read, so the write cycle is not a hazard
  assign bus.rs_busy = pending_q[bus.rs_addr] & ~(r3_wr_q & (r3_addr_q == bus.rs_addr));
  assign bus.rt_busy = pending_q[bus.rt_addr] & ~(r3_wr_q & (r3_addr_q == bus.rt_addr));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write port, round robin, $zero,
// scoreboard collisions and asynchronous reset.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.flush       = 1'b0;
    bus.rs_addr     = '0;
    bus.rt_addr     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.r3_wr !== 1'b0) begin errors++; $display("FAIL reset_r3_wr got %h exp 0", bus.r3_wr); end
    checks++; if (bus.r3_addr !== 5'd0) begin errors++; $display("FAIL reset_r3_addr got %h exp 0", bus.r3_addr); end
    checks++; if (bus.r3_din !== 32'd0) begin errors++; $display("FAIL reset_r3_din got %h exp 0", bus.r3_din); end
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending_mask); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", bus.req_ready); end
  endtask

  task automatic test_single_write();
    tick();
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd5;
    tick();
    bus.alloc_valid = 1'b0;
    bus.rs_addr     = 5'd5;
    #1;
    checks++; if (bus.pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL single_pending_set got %h exp 00000020", bus.pending_mask); end
    checks++; if (bus.rs_busy !== 1'b1) begin errors++; $display("FAIL single_rs_busy got %b exp 1", bus.rs_busy); end
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd5};
    bus.req_data  = {32'd0, 32'd0, 32'hDEAD_BEEF};
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", bus.req_ready); end
    checks++; if (bus.rs_busy !== 1'b1) begin errors++; $display("FAIL single_rs_busy_pre got %b exp 1", bus.rs_busy); end
    tick();
    bus.req_valid = 3'b000;
    #1;
    checks++; if (bus.r3_wr !== 1'b1) begin errors++; $display("FAIL single_r3_wr got %b exp 1", bus.r3_wr); end
    checks++; if (bus.r3_addr !== 5'd5) begin errors++; $display("FAIL single_r3_addr got %h exp 05", bus.r3_addr); end
    checks++; if (bus.r3_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_r3_din got %h exp deadbeef", bus.r3_din); end
    checks++; if (bus.rs_busy !== 1'b0) begin errors++; $display("FAIL single_rs_busy_wr got %b exp 0", bus.rs_busy); end
    tick();
    checks++; if (bus.r3_wr !== 1'b0) begin errors++; $display("FAIL single_r3_wr_drop got %b exp 0", bus.r3_wr); end
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL single_pending_clr got %h exp 0", bus.pending_mask); end
    bus.rs_addr = 5'd0;
  endtask

  task automatic test_round_robin();
    logic [4:0]  addrs [3];
    logic [31:0] datas [3];
    logic [2:0]  exp_rdy;
    int          g;
    addrs[0] = 5'd10; addrs[1] = 5'd11; addrs[2] = 5'd12;
    datas[0] = 32'hA000_000A; datas[1] = 32'hB000_000B; datas[2] = 32'hC000_000C;
    bus.req_addr = {addrs[2], addrs[1], addrs[0]};
    bus.req_data = {datas[2], datas[1], datas[0]};
    // previous grant was requester 0; a lone req2 grant brings the pointer back to 0
    bus.req_valid = 3'b100;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL rr_prime_ready got %b exp 100", bus.req_ready); end
    tick();
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      exp_rdy = 3'b001 << g;
      #1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", c, bus.req_ready, exp_rdy); end
      tick();
      checks++; if (bus.r3_wr !== 1'b1 || bus.r3_addr !== addrs[g] || bus.r3_din !== datas[g])
        begin errors++; $display("FAIL rr_write[%0d] got wr=%b addr=%h din=%h exp wr=1 addr=%h din=%h", c, bus.r3_wr, bus.r3_addr, bus.r3_din, addrs[g], datas[g]); end
    end
    bus.req_valid = 3'b100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL rr_solo_ready[%0d] got %b exp 100", c, bus.req_ready); end
      tick();
      checks++; if (bus.r3_wr !== 1'b1 || bus.r3_addr !== 5'd12) begin errors++; $display("FAIL rr_solo_write[%0d] got wr=%b addr=%h exp wr=1 addr=0c", c, bus.r3_wr, bus.r3_addr); end
    end
    bus.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_zero_reg();
    bus.req_addr  = {5'd0, 5'd0, 5'd0};
    bus.req_data  = {32'd0, 32'h0000_1234, 32'd0};
    bus.req_valid = 3'b010;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL zero_ready got %b exp 010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    #1;
    checks++; if (bus.r3_wr !== 1'b0) begin errors++; $display("FAIL zero_r3_wr got %b exp 0", bus.r3_wr); end
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL zero_pending got %h exp 0", bus.pending_mask); end
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd0;
    tick();
    bus.alloc_valid = 1'b0;
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL zero_alloc got %h exp 0", bus.pending_mask); end
  endtask

  task automatic test_collision();
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd7;
    tick();
    bus.alloc_valid = 1'b0;
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL coll_pending_set got %h exp 00000080", bus.pending_mask); end
    // pointer sits at 2 after the $zero grant; req0 is the next valid
    bus.req_addr  = {5'd0, 5'd0, 5'd7};
    bus.req_data  = {32'd0, 32'd0, 32'h0770_0777};
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL coll_ready got %b exp 001", bus.req_ready); end
    tick();
    bus.req_valid   = 3'b000;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd7;
    bus.rt_addr     = 5'd7;
    #1;
    checks++; if (bus.r3_wr !== 1'b1 || bus.r3_addr !== 5'd7) begin errors++; $display("FAIL coll_r3 got wr=%b addr=%h exp wr=1 addr=07", bus.r3_wr, bus.r3_addr); end
    checks++; if (bus.rt_busy !== 1'b0) begin errors++; $display("FAIL coll_rt_busy_wr got %b exp 0", bus.rt_busy); end
    tick();
    bus.alloc_valid = 1'b0;
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL coll_set_wins got %h exp 00000080", bus.pending_mask); end
    checks++; if (bus.rt_busy !== 1'b1) begin errors++; $display("FAIL coll_rt_busy got %b exp 1", bus.rt_busy); end
    // flush variant, with an extra reservation on reg 9
    bus.req_valid   = 3'b001;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd9;
    tick();
    bus.req_valid   = 3'b000;
    bus.alloc_addr  = 5'd7;
    bus.flush       = 1'b1;
    #1;
    checks++; if (bus.pending_mask !== 32'h0000_0280) begin errors++; $display("FAIL coll_pending_pre_flush got %h exp 00000280", bus.pending_mask); end
    checks++; if (bus.r3_wr !== 1'b1 || bus.r3_din !== 32'h0770_0777) begin errors++; $display("FAIL coll_flush_write got wr=%b din=%h exp wr=1 din=07700777", bus.r3_wr, bus.r3_din); end
    tick();
    bus.alloc_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.rt_addr     = 5'd0;
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL coll_flush got %h exp 0", bus.pending_mask); end
  endtask

  task automatic test_async_reset();
    bus.req_addr    = {5'd22, 5'd21, 5'd20};
    bus.req_data    = {32'h2222_2222, 32'h2121_2121, 32'h2020_2020};
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd30;
    tick();
    bus.alloc_valid = 1'b0;
    bus.req_valid   = 3'b111;
    tick();
    tick();
    #1;
    checks++; if (bus.r3_wr !== 1'b1) begin errors++; $display("FAIL areset_pre_wr got %b exp 1", bus.r3_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.r3_wr !== 1'b0) begin errors++; $display("FAIL areset_r3_wr got %b exp 0", bus.r3_wr); end
    checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL areset_pending got %h exp 0", bus.pending_mask); end
    checks++; if (bus.r3_addr !== 5'd0 || bus.r3_din !== 32'd0) begin errors++; $display("FAIL areset_port got addr=%h din=%h exp 0 0", bus.r3_addr, bus.r3_din); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL areset_first_grant got %b exp 001", bus.req_ready); end
    tick();
    checks++; if (bus.r3_wr !== 1'b1 || bus.r3_addr !== 5'd20 || bus.r3_din !== 32'h2020_2020)
      begin errors++; $display("FAIL areset_first_write got wr=%b addr=%h din=%h exp wr=1 addr=14 din=20202020", bus.r3_wr, bus.r3_addr, bus.r3_din); end
    bus.req_valid = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_zero_reg();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
